// File: rtl/exe_alu_stage_if.sv
// Bus between the ID/EXE register side and the execute stage.
//   master : upstream view, drives instruction fields and control, reads results
//   slave  : execute stage view, reads instruction fields, drives EXE/MEM results
//   Inputs to stage : freeze, flush, valid_in, exe_cmd, s_in, b_in, wb_en_in,
//                     mem_r_en_in, mem_w_en_in, dest_in, val_rn, val2, val_rm,
//                     pc_in, imm24
//   Outputs of stage: alu_res, st_val, dest_out, wb_en_out, mem_r_en_out,
//                     mem_w_en_out, valid_out, sr, branch_taken, branch_addr
interface exe_alu_stage_if #(
    parameter int unsigned DW = 32
);
    logic          freeze;
    logic          flush;
    logic          valid_in;
    logic [3:0]    exe_cmd;
    logic          s_in;
    logic          b_in;
    logic          wb_en_in;
    logic          mem_r_en_in;
    logic          mem_w_en_in;
    logic [3:0]    dest_in;
    logic [DW-1:0] val_rn;
    logic [DW-1:0] val2;
    logic [DW-1:0] val_rm;
    logic [DW-1:0] pc_in;
    logic [23:0]   imm24;

    logic [DW-1:0] alu_res;
    logic [DW-1:0] st_val;
    logic [3:0]    dest_out;
    logic          wb_en_out;
    logic          mem_r_en_out;
    logic          mem_w_en_out;
    logic          valid_out;
    logic [3:0]    sr;
    logic          branch_taken;
    logic [DW-1:0] branch_addr;

    modport master (
        output freeze, flush, valid_in, exe_cmd, s_in, b_in, wb_en_in,
               mem_r_en_in, mem_w_en_in, dest_in, val_rn, val2, val_rm,
               pc_in, imm24,
        input  alu_res, st_val, dest_out, wb_en_out, mem_r_en_out,
               mem_w_en_out, valid_out, sr, branch_taken, branch_addr
    );

    modport slave (
        input  freeze, flush, valid_in, exe_cmd, s_in, b_in, wb_en_in,
               mem_r_en_in, mem_w_en_in, dest_in, val_rn, val2, val_rm,
               pc_in, imm24,
        output alu_res, st_val, dest_out, wb_en_out, mem_r_en_out,
               mem_w_en_out, valid_out, sr, branch_taken, branch_addr
    );
endinterface

// File: rtl/exe_alu_stage.sv
// Execute stage: ALU + NZCV status register + branch target, results
// registered into the EXE/MEM pipeline register with freeze/flush support.
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : exe_alu_stage_if.slave (instruction fields in, EXE/MEM results out;
//         branch_taken/branch_addr are combinational on current inputs)
module exe_alu_stage #(
    parameter int unsigned DW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    exe_alu_stage_if.slave       bus
);
    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_ORR = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;

    logic [DW-1:0] r_alu_res;
    logic [DW-1:0] r_st_val;
    logic [3:0]    r_dest;
    logic          r_wb_en;
    logic          r_mem_r_en;
    logic          r_mem_w_en;
    logic          r_valid;
    logic [3:0]    r_sr;

    logic          w_arith;
    logic [DW-1:0] w_opb;
    logic          w_cin;
    logic [DW-1:0] w_logic_res;
    logic [DW:0]   w_sum;
    logic [DW-1:0] w_res;
    logic [3:0]    w_flags;
    logic          w_load;
    logic [DW-1:0] w_imm_ext;

    // Operand/carry selection; subtraction runs as rn + ~val2 + cin
    always_comb begin
        w_arith     = 1'b0;
        w_opb       = bus.val2;
        w_cin       = 1'b0;
        w_logic_res = '0;
        case (bus.exe_cmd)
            OP_ADD: w_arith = 1'b1;
            OP_ADC: begin w_arith = 1'b1; w_cin = r_sr[1]; end
            OP_SUB: begin w_arith = 1'b1; w_opb = ~bus.val2; w_cin = 1'b1; end
            OP_SBC: begin w_arith = 1'b1; w_opb = ~bus.val2; w_cin = r_sr[1]; end
            OP_MOV: w_logic_res = bus.val2;
            OP_MVN: w_logic_res = ~bus.val2;
            OP_AND: w_logic_res = bus.val_rn & bus.val2;
            OP_ORR: w_logic_res = bus.val_rn | bus.val2;
            OP_EOR: w_logic_res = bus.val_rn ^ bus.val2;
            default: w_logic_res = '0;
        endcase
    end

    assign w_sum = {1'b0, bus.val_rn} + {1'b0, w_opb} + (DW+1)'(w_cin);
    assign w_res = w_arith ? w_sum[DW-1:0] : w_logic_res;

    // Logical ops keep C and V; overflow uses the effective second operand
    always_comb begin
        w_flags[3] = w_res[DW-1];
        w_flags[2] = (w_res == '0);
        w_flags[1] = w_arith ? w_sum[DW] : r_sr[1];
        w_flags[0] = w_arith ? ((bus.val_rn[DW-1] == w_opb[DW-1]) &&
                                (w_res[DW-1] != bus.val_rn[DW-1]))
                             : r_sr[0];
    end

    assign w_load    = bus.valid_in & ~bus.flush;
    assign w_imm_ext = {{(DW-26){bus.imm24[23]}}, bus.imm24, 2'b00};

    // EXE/MEM register: reset > freeze > bubble > load
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_alu_res  <= '0;
            r_st_val   <= '0;
            r_dest     <= '0;
            r_wb_en    <= 1'b0;
            r_mem_r_en <= 1'b0;
            r_mem_w_en <= 1'b0;
            r_valid    <= 1'b0;
            r_sr       <= '0;
        end else if (!bus.freeze) begin
            r_alu_res  <= w_res;
            r_st_val   <= bus.val_rm;
            r_dest     <= bus.dest_in;
            r_wb_en    <= w_load & bus.wb_en_in;
            r_mem_r_en <= w_load & bus.mem_r_en_in;
            r_mem_w_en <= w_load & bus.mem_w_en_in;
            r_valid    <= w_load;
            if (w_load && bus.s_in) begin
                r_sr <= w_flags;
            end
        end
    end

    assign bus.alu_res      = r_alu_res;
    assign bus.st_val       = r_st_val;
    assign bus.dest_out     = r_dest;
    assign bus.wb_en_out    = r_wb_en;
    assign bus.mem_r_en_out = r_mem_r_en;
    assign bus.mem_w_en_out = r_mem_w_en;
    assign bus.valid_out    = r_valid;
    assign bus.sr           = r_sr;
    assign bus.branch_taken = bus.valid_in & bus.b_in & ~bus.flush;
    assign bus.branch_addr  = bus.pc_in + w_imm_ext;
endmodule

// File: doc/exe_alu_stage.md
Name: exe_alu_stage

Overview:
- Execute-stage datapath that consumes the second operand produced by the val2 generator.
- Performs the ALU operation and maintains the NZCV status register.
- Computes the branch target and registers all results into the EXE/MEM pipeline register.
- Supports a freeze (stall) and a flush (bubble insert) from the hazard/memory control.

Parameters:
- DW, 32, datapath width (fixed at 32 for ARM; parameter kept for the bench only).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- freeze  in  1  hold all registered state this cycle.
- flush  in  1  replace the incoming instruction with a bubble.
- valid_in  in  1  ID/EXE slot holds a real instruction.
- exe_cmd  in  4  ALU operation code.
- s_in  in  1  instruction updates status flags.
- b_in  in  1  instruction is a branch (condition already resolved in ID).
- wb_en_in, mem_r_en_in, mem_w_en_in  in  1 each  control bits passed down the pipe.
- dest_in  in  4  destination register number.
- val_rn  in  32  first operand.
- val2  in  32  second operand from the val2 generator.
- val_rm  in  32  store data, passed through.
- pc_in  in  32  PC of the next instruction.
- imm24  in  24  branch offset field.
- alu_res  out  32  registered ALU result.
- st_val  out  32  registered copy of val_rm.
- dest_out  out  4  registered destination register.
- wb_en_out, mem_r_en_out, mem_w_en_out, valid_out  out  1 each  registered control.
- sr  out  4  status register {N,Z,C,V}.
- branch_taken  out  1  combinational: valid_in & b_in & ~flush.
- branch_addr  out  32  combinational: pc_in + (sign_ext(imm24) << 2), mod 2^32.

Behaviour:
- Reset (rst==0 at a clk edge): every registered output and sr become 0. Reset has priority over freeze and flush and may occur mid-stream; the in-flight instruction is dropped.
- ALU is combinational on the current inputs, using C = sr[1]:
  - 0001 MOV: val2.
  - 1001 MVN: ~val2.
  - 0010 ADD (also LDR/STR address): rn+val2.
  - 0011 ADC: rn+val2+C.
  - 0100 SUB/CMP: rn-val2.
  - 0101 SBC: rn-val2-(~C).
  - 0110 AND/TST: rn&val2.
  - 0111 ORR: rn|val2.
  - 1000 EOR: rn^val2.
  - Any other code: result 0, flags treated as a logical op.
- Flags:
  - N = res[31]; Z = (res==0).
  - Arithmetic ops: C is the 33rd bit of the addition; subtraction is computed as rn + ~val2 + 1 (or + C for SBC), so C=1 means no borrow. V = signed overflow.
  - Logical ops, MOV and MVN: C and V keep their current sr values.
- Pipeline register update, one cycle latency, evaluated in this priority at each clk edge:
  - rst==0: clear all.
  - freeze==1: hold all outputs and sr.
  - flush==1 or valid_in==0: load a bubble. valid_out, wb_en_out, mem_r_en_out and mem_w_en_out become 0; data fields load their inputs (don't-care); sr unchanged.
  - Otherwise: load all outputs from the inputs and ALU result; valid_out=1.
- sr update: sr loads the new flags at the edge when rst==1 & ~freeze & ~flush & valid_in & s_in. There is no other update path.
- Back-to-back flag dependence: instruction k+1 in EXE sees sr written by instruction k at the preceding edge; no internal bypass is required.
- Simultaneous freeze and flush: freeze wins; flush is ignored that cycle. The controller re-asserts flush if it is still needed.
- branch_taken and branch_addr depend on current inputs only and are unaffected by freeze. The IF stage must qualify them with its own stall.

Test Plan:
- Reset: drive rst=0 for 2 edges with valid_in=1 and ADD -> alu_res=0, valid_out=0, sr=0000; after rst=1, ADD rn=5, val2=7 -> alu_res=12, valid_out=1 after one edge.
- ADDS overflow: s_in=1, rn=0x7FFFFFFF, val2=1 -> alu_res=0x80000000, sr=N1 Z0 C0 V1. Then SUBS rn=3, val2=3 -> res=0, sr=0110.
- ADC/SBC chain: set C=1 via ADDS 0xFFFFFFFF+1 (sr=0110). Then ADC rn=1, val2=1 -> 3. Then SBC without S, rn=5, val2=2 -> 3 (C still 1); with C=0, SBC gives 2.
- Logical flag preservation: sr=0011, then ANDS rn=0xF0, val2=0x0F -> res=0, sr=0111 (C,V kept).
- Freeze/flush: hold freeze=1 for 3 cycles while inputs change -> outputs and sr frozen. freeze=1 & flush=1 -> hold. flush only with SUBS, s=1 -> bubble, wb_en_out=0, sr unchanged.
- Branch: valid_in=1, b_in=1, pc_in=0x100, imm24=0xFFFFFE -> branch_taken=1, branch_addr=0xF8 in the same cycle; with flush=1 -> branch_taken=0.
